// File: rtl/seq_detector_p_if.sv
// Symbol-stream, pattern-programming and status bundle for seq_detector_p.
// The board top level (master) drives symbols and commands; the detector (slave) reports matches.
interface seq_detector_p_if #(
    parameter int SYM_W   = 2,
    parameter int SEQ_LEN = 5,
    parameter int CNT_W   = 8
);
    localparam int PROG_W = $clog2(SEQ_LEN + 1);

    logic                     pattern_load;
    logic [SEQ_LEN*SYM_W-1:0] pattern_in;
    logic                     sym_valid;
    logic [SYM_W-1:0]         sym;
    logic                     clear;
    logic                     match_pulse;
    logic                     led;
    logic [CNT_W-1:0]         match_count;
    logic [PROG_W-1:0]        progress;

    modport master (
        output pattern_load, pattern_in, sym_valid, sym, clear,
        input  match_pulse, led, match_count, progress
    );

    modport slave (
        input  pattern_load, pattern_in, sym_valid, sym, clear,
        output match_pulse, led, match_count, progress
    );
endinterface

// File: rtl/seq_detector_p.sv
// Programmable SEQ_LEN-symbol sequence detector with match pulse, sticky LED, saturating count and progress.
// Optional idle-timeout history flush is compiled in when MATCH_TIMEOUT_EN is defined.
module seq_detector_p #(
    parameter int                           SYM_W       = 2,
    parameter int                           SEQ_LEN     = 5,
    parameter logic [SEQ_LEN*SYM_W-1:0]     DEFAULT_PAT = {2'b01, 2'b10, 2'b11, 2'b10, 2'b01},
    parameter bit                           OVERLAP     = 1'b1,
    parameter int                           CNT_W       = 8,
    parameter int                           TIMEOUT_CYC = 16
) (
    input  logic            clk,
    input  logic            reset,
    seq_detector_p_if.slave bus
);
    localparam int                W         = SEQ_LEN * SYM_W;
    localparam int                PROG_W    = $clog2(SEQ_LEN + 1);
    localparam logic [PROG_W-1:0] FILL_FULL = PROG_W'(SEQ_LEN);
    localparam logic [PROG_W-1:0] FILL_NEED = PROG_W'(SEQ_LEN - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    if (SEQ_LEN < 2 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("seq_detector_p: SEQ_LEN must be >= 2 and TIMEOUT_CYC >= 1");
    end

    // History slot 0 holds the oldest symbol, slot SEQ_LEN-1 the newest, matching pattern packing.
    logic [W-1:0]      pat_q, pat_d;
    logic [W-1:0]      hist_q, hist_d, hist_shift;
    logic [PROG_W-1:0] fill_q, fill_d;
    logic [PROG_W-1:0] progress_q, progress_d;
    logic              pulse_q, pulse_d;
    logic              led_q, led_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              match;

`ifdef MATCH_TIMEOUT_EN
    localparam int                IDLE_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);
    logic [IDLE_W-1:0] idle_q, idle_d;
`endif

    // Longest k such that the newest k valid history symbols equal pattern symbols 0..k-1.
    function automatic logic [PROG_W-1:0] prefix_len(
        input logic [W-1:0]      h,
        input logic [W-1:0]      p,
        input logic [PROG_W-1:0] f
    );
        logic [PROG_W-1:0] best;
        logic              ok;
        best = '0;
        for (int k = 1; k <= SEQ_LEN; k++) begin
            ok = (PROG_W'(k) <= f);
            for (int i = 0; i < k; i++) begin
                if (h[(SEQ_LEN-k+i)*SYM_W +: SYM_W] != p[i*SYM_W +: SYM_W]) ok = 1'b0;
            end
            if (ok) best = PROG_W'(k);
        end
        return best;
    endfunction

    always_comb begin
        // NOTE: every value this block writes gets a default first, so no path can infer a latch.
        pat_d      = pat_q;
        hist_d     = hist_q;
        fill_d     = fill_q;
        led_d      = led_q;
        count_d    = count_q;
        pulse_d    = 1'b0;
        match      = 1'b0;
        hist_shift = {bus.sym, hist_q[W-1:SYM_W]};
`ifdef MATCH_TIMEOUT_EN
        idle_d     = '0;
`endif
        if (bus.pattern_load) begin
            pat_d  = bus.pattern_in;
            fill_d = '0;
        end else begin
            if (bus.clear) begin
                led_d   = 1'b0;
                count_d = '0;
            end
            if (bus.sym_valid) begin
                hist_d = hist_shift;
                fill_d = (fill_q == FILL_FULL) ? fill_q : fill_q + PROG_W'(1);
                match  = (fill_q >= FILL_NEED) && (hist_shift == pat_q);
                if (match) begin
                    pulse_d = 1'b1;
                    led_d   = 1'b1;
                    // count_d already reflects a same-cycle clear, so clear+match yields 1.
                    if (count_d != CNT_MAX) count_d = count_d + CNT_W'(1);
                    if (!OVERLAP) fill_d = '0;
                end
            end
`ifdef MATCH_TIMEOUT_EN
            else if (fill_q != '0) begin
                if (idle_q == IDLE_LAST) fill_d = '0;
                else                     idle_d = idle_q + IDLE_W'(1);
            end
`endif
        end
        progress_d = prefix_len(hist_d, pat_d, fill_d);
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            pat_q      <= DEFAULT_PAT;
            fill_q     <= '0;
            progress_q <= '0;
            pulse_q    <= 1'b0;
            led_q      <= 1'b0;
            count_q    <= '0;
        end else begin
            pat_q      <= pat_d;
            fill_q     <= fill_d;
            progress_q <= progress_d;
            pulse_q    <= pulse_d;
            led_q      <= led_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: history data is deliberately not reset; slots outside fill are never compared.
        hist_q <= hist_d;
    end

`ifdef MATCH_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) idle_q <= '0;
        else       idle_q <= idle_d;
    end
`endif

    assign bus.match_pulse = pulse_q;
    assign bus.led         = led_q;
    assign bus.match_count = count_q;
    assign bus.progress    = progress_q;
endmodule
